mcpu_ctrl_fsm: RTL and testbench

//  Multi-cycle MIPS controller, successor to the base multi-cycle ctrl FSM. Adds I-type ALU ops, lui, bne,
//  jal and jr, memory wait states, and an overflow trap. Drives the OExp multi-cycle datapath.

---
 rtl/mcpu_defs_pkg.sv | 189 ++++++++++++++++++
 rtl/mcpu_alu_dec.sv | 56 +++++
 rtl/mcpu_ctrl_fsm.sv | 146 ++++++++++++++
 tb/tb_mcpu_ctrl_fsm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_defs_pkg.sv
// Shared definitions for the multi-cycle MIPS controller:
// state codes, opcodes, ALU codes, datapath selects, output decode.
package mcpu_defs_pkg;

   typedef enum logic [4:0] {
      S_IF      = 5'd0,
      S_ID      = 5'd1,
      S_MEM_EX  = 5'd2,
      S_MEM_RD  = 5'd3,
      S_LW_WB   = 5'd4,
      S_MEM_W   = 5'd5,
      S_R_EXC   = 5'd6,
      S_R_WB    = 5'd7,
      S_BEQ_EXC = 5'd8,
      S_J       = 5'd9,
      S_I_EXC   = 5'd10,
      S_I_WB    = 5'd11,
      S_LUI_WB  = 5'd12,
      S_BNE_EXC = 5'd13,
      S_JAL     = 5'd14,
      S_JR      = 5'd15,
      S_ERROR   = 5'd31
   } state_t;

   typedef enum logic [1:0] {
      AO_ADD   = 2'd0,
      AO_SUB   = 2'd1,
      AO_FUNCT = 2'd2,
      AO_IMM   = 2'd3
   } aluop_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_XORI = 6'b001110;
   localparam logic [5:0] OP_LUI  = 6'b001111;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_XOR = 6'b100110;
   localparam logic [5:0] F_NOR = 6'b100111;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_SRL = 6'b000010;
   localparam logic [5:0] F_JR  = 6'b001000;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_XOR = 3'd3;
   localparam logic [2:0] ALU_NOR = 3'd4;
   localparam logic [2:0] ALU_SRL = 3'd5;
   localparam logic [2:0] ALU_SUB = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MDR = 2'b01;
   localparam logic [1:0] M2R_LUI = 2'b10;
   localparam logic [1:0] M2R_PC  = 2'b11;

   localparam logic [1:0] SRCB_B   = 2'b00;
   localparam logic [1:0] SRCB_4   = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;
   localparam logic [1:0] SRCB_SH  = 2'b11;

   localparam logic [1:0] PCS_ALU = 2'b00;
   localparam logic [1:0] PCS_OUT = 2'b01;
   localparam logic [1:0] PCS_JMP = 2'b10;
   localparam logic [1:0] PCS_RS  = 2'b11;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       cpu_mio;
      logic       iord;
      logic       reg_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       alu_src_a;
      logic       branch;
      logic       alu_en;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      aluop_t     alu_op;
   } ctrl_t;

   // Moore output decode; alu_en marks states that drive an ALU function.
   function automatic ctrl_t ctrl_dec(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_IF: begin
            c.mem_read  = 1'b1;
            c.cpu_mio   = 1'b1;
            c.alu_src_b = SRCB_4;
            c.alu_en    = 1'b1;
            c.alu_op    = AO_ADD;
         end
         S_ID: begin
            c.alu_src_b = SRCB_SH;
            c.alu_en    = 1'b1;
            c.alu_op    = AO_ADD;
         end
         S_MEM_EX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_en    = 1'b1;
            c.alu_op    = AO_ADD;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
            c.cpu_mio  = 1'b1;
         end
         S_MEM_W: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
            c.cpu_mio   = 1'b1;
         end
         S_LW_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = M2R_MDR;
         end
         S_R_EXC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_en    = 1'b1;
            c.alu_op    = AO_FUNCT;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = RD_RD;
         end
         S_I_EXC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_en    = 1'b1;
            c.alu_op    = AO_IMM;
         end
         S_I_WB: c.reg_write = 1'b1;
         S_LUI_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = M2R_LUI;
         end
         S_BEQ_EXC, S_BNE_EXC: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_B;
            c.alu_en        = 1'b1;
            c.alu_op        = AO_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCS_OUT;
            c.branch        = (s == S_BEQ_EXC);
         end
         S_J: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCS_JMP;
         end
         S_JAL: begin
            c.pc_write   = 1'b1;
            c.pc_source  = PCS_JMP;
            c.reg_write  = 1'b1;
            c.reg_dst    = RD_RA;
            c.mem_to_reg = M2R_PC;
         end
         S_JR: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCS_RS;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// ALU function decoder: alu_op class plus opcode/funct
// to ALU code and immediate zero-extend select.
import mcpu_defs_pkg::*;

module mcpu_alu_dec (
   input  aluop_t     alu_op_i,
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_operation_o,
   output logic       ext_zero_o
);

   // Unknown funct/opcode falls back to ADD.
   always_comb begin
      alu_operation_o = ALU_ADD;
      ext_zero_o      = 1'b0;
      case (alu_op_i)
         AO_ADD: alu_operation_o = ALU_ADD;
         AO_SUB: alu_operation_o = ALU_SUB;
         AO_FUNCT: begin
            case (funct_i)
               F_ADD:   alu_operation_o = ALU_ADD;
               F_SUB:   alu_operation_o = ALU_SUB;
               F_AND:   alu_operation_o = ALU_AND;
               F_OR:    alu_operation_o = ALU_OR;
               F_XOR:   alu_operation_o = ALU_XOR;
               F_NOR:   alu_operation_o = ALU_NOR;
               F_SLT:   alu_operation_o = ALU_SLT;
               F_SRL:   alu_operation_o = ALU_SRL;
               default: alu_operation_o = ALU_ADD;
            endcase
         end
         AO_IMM: begin
            case (op_i)
               OP_ADDI: alu_operation_o = ALU_ADD;
               OP_SLTI: alu_operation_o = ALU_SLT;
               OP_ANDI: begin
                  alu_operation_o = ALU_AND;
                  ext_zero_o      = 1'b1;
               end
               OP_ORI: begin
                  alu_operation_o = ALU_OR;
                  ext_zero_o      = 1'b1;
               end
               OP_XORI: begin
                  alu_operation_o = ALU_XOR;
                  ext_zero_o      = 1'b1;
               end
               default: alu_operation_o = ALU_ADD;
            endcase
         end
         default: alu_operation_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS controller: registered Moore outputs,
// plus ready-qualified fetch strobes that are Mealy.
import mcpu_defs_pkg::*;

module mcpu_ctrl_fsm #(
   parameter int ALU_OP_W    = 3,
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter bit OVF_TRAP    = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         inst_in,
   input  logic                zero,
   input  logic                overflow,
   input  logic                mio_ready,
   output logic                mem_read,
   output logic                mem_write,
   output logic                cpu_mio,
   output logic                iord,
   output logic                ir_write,
   output logic                reg_write,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                alu_src_a,
   output logic                ext_zero,
   output logic                branch,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_source,
   output logic [ALU_OP_W-1:0] alu_operation,
   output logic [4:0]          state_out
);

   logic [5:0] op;
   logic [5:0] funct;
   state_t     state_q, state_d;
   ctrl_t      ctrl_q, ctrl_d;
   logic [2:0] alu_q, alu_d, dec_alu;
   logic       ez_q, ez_d, dec_ez;
   logic       ovf_trap;
   logic       mem_go;
   logic       if_rdy;
   logic       unused_bits;

   assign op          = inst_in[31:26];
   assign funct       = inst_in[5:0];
   assign unused_bits = ^{inst_in[28:6], zero};
   assign ovf_trap    = OVF_TRAP && overflow;
   assign mem_go      = !MEM_WAIT_EN || mio_ready;

   // Next-state selection, including ID decode and overflow trap.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF:     if (mio_ready) state_d = S_ID;
         S_ID: begin
            case (op)
               OP_R:    state_d = (funct == F_JR) ? S_JR : S_R_EXC;
               OP_LW,
               OP_SW:   state_d = S_MEM_EX;
               OP_BEQ:  state_d = S_BEQ_EXC;
               OP_BNE:  state_d = S_BNE_EXC;
               OP_J:    state_d = S_J;
               OP_JAL:  state_d = S_JAL;
               OP_ADDI,
               OP_SLTI,
               OP_ANDI,
               OP_ORI,
               OP_XORI: state_d = S_I_EXC;
               OP_LUI:  state_d = S_LUI_WB;
               default: state_d = S_ERROR;
            endcase
         end
         S_MEM_EX: state_d = inst_in[29] ? S_MEM_W : S_MEM_RD;
         S_MEM_RD: if (mem_go) state_d = S_LW_WB;
         S_MEM_W:  if (mem_go) state_d = S_IF;
         S_R_EXC: begin
            if (ovf_trap && (funct == F_ADD || funct == F_SUB))
               state_d = S_ERROR;
            else
               state_d = S_R_WB;
         end
         S_I_EXC: begin
            if (ovf_trap && op == OP_ADDI)
               state_d = S_ERROR;
            else
               state_d = S_I_WB;
         end
         S_LW_WB, S_R_WB, S_I_WB, S_LUI_WB,
         S_BEQ_EXC, S_BNE_EXC,
         S_J, S_JAL, S_JR: state_d = S_IF;
         S_ERROR:  state_d = S_ERROR;
         default:  state_d = S_ERROR;
      endcase
   end

   assign ctrl_d = ctrl_dec(state_d);

   mcpu_alu_dec u_alu_dec (
      .alu_op_i        (ctrl_d.alu_op),
      .op_i            (op),
      .funct_i         (funct),
      .alu_operation_o (dec_alu),
      .ext_zero_o      (dec_ez)
   );

   assign alu_d = ctrl_d.alu_en ? dec_alu : ALU_AND;
   assign ez_d  = ctrl_d.alu_en & dec_ez;

   // State and output registers; reset loads the IF decode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IF;
         ctrl_q  <= ctrl_dec(S_IF);
         alu_q   <= ALU_ADD;
         ez_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         alu_q   <= alu_d;
         ez_q    <= ez_d;
      end
   end

   assign if_rdy = (state_q == S_IF) && mio_ready && !reset;

   assign mem_read      = ctrl_q.mem_read;
   assign mem_write     = ctrl_q.mem_write;
   assign cpu_mio       = ctrl_q.cpu_mio;
   assign iord          = ctrl_q.iord;
   assign ir_write      = if_rdy;
   assign reg_write     = ctrl_q.reg_write;
   assign pc_write      = ctrl_q.pc_write | if_rdy;
   assign pc_write_cond = ctrl_q.pc_write_cond;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign ext_zero      = ez_q;
   assign branch        = ctrl_q.branch;
   assign reg_dst       = ctrl_q.reg_dst;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign pc_source     = ctrl_q.pc_source;
   assign alu_operation = ALU_OP_W'(alu_q);
   assign state_out     = state_q;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Scoreboard bench for mcpu_ctrl_fsm: expected state and
// outputs queued per driven cycle, compared on the falling edge.
module tb_mcpu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inst_in;
   logic        zero, overflow, mio_ready;
   logic        mem_read, mem_write, cpu_mio, iord, ir_write;
   logic        reg_write, pc_write, pc_write_cond, alu_src_a;
   logic        ext_zero, branch;
   logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
   logic [2:0]  alu_operation;
   logic [4:0]  state_out;

   int n_cmp = 0;
   int n_err = 0;

   string      q_tag[$];
   logic [4:0] q_st[$];
   logic [21:0] q_vec[$];

   logic [21:0] obs;

   mcpu_ctrl_fsm dut (
      .clk           (clk),
      .reset         (reset),
      .inst_in       (inst_in),
      .zero          (zero),
      .overflow      (overflow),
      .mio_ready     (mio_ready),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .cpu_mio       (cpu_mio),
      .iord          (iord),
      .ir_write      (ir_write),
      .reg_write     (reg_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .alu_src_a     (alu_src_a),
      .ext_zero      (ext_zero),
      .branch        (branch),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .alu_src_b     (alu_src_b),
      .pc_source     (pc_source),
      .alu_operation (alu_operation),
      .state_out     (state_out)
   );

   always #5 clk = ~clk;

   assign obs = {mem_read, mem_write, cpu_mio, iord, ir_write,
                 reg_write, pc_write, pc_write_cond, alu_src_a,
                 ext_zero, branch, reg_dst, mem_to_reg,
                 alu_src_b, pc_source, alu_operation};

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference output model per state.
   function automatic logic [21:0] mdl(logic [4:0] st, logic rdy,
                                       logic [31:0] ins);
      logic mr, mw, cm, io, ir, rw, pw, pwc, sa, ez, br;
      logic [1:0] rd, m2r, sb, ps;
      logic [2:0] ao;
      {mr, mw, cm, io, ir, rw, pw, pwc, sa, ez, br} = '0;
      {rd, m2r, sb, ps} = '0;
      ao = 3'd0;
      case (st)
         5'd0:  begin mr = 1; cm = 1; ir = rdy; pw = rdy;
                      sb = 2'b01; ao = 3'd2; end
         5'd1:  begin sb = 2'b11; ao = 3'd2; end
         5'd2:  begin sa = 1; sb = 2'b10; ao = 3'd2; end
         5'd3:  begin mr = 1; io = 1; cm = 1; end
         5'd4:  begin rw = 1; m2r = 2'b01; end
         5'd5:  begin mw = 1; io = 1; cm = 1; end
         5'd6: begin
            sa = 1;
            case (ins[5:0])
               6'h20: ao = 3'd2;
               6'h22: ao = 3'd6;
               6'h24: ao = 3'd0;
               6'h25: ao = 3'd1;
               6'h26: ao = 3'd3;
               6'h27: ao = 3'd4;
               6'h2a: ao = 3'd7;
               6'h02: ao = 3'd5;
               default: ao = 3'd2;
            endcase
         end
         5'd7:  begin rw = 1; rd = 2'b01; end
         5'd8:  begin sa = 1; ao = 3'd6; pwc = 1; ps = 2'b01; br = 1; end
         5'd13: begin sa = 1; ao = 3'd6; pwc = 1; ps = 2'b01; end
         5'd9:  begin pw = 1; ps = 2'b10; end
         5'd10: begin
            sa = 1; sb = 2'b10;
            case (ins[31:26])
               6'h08: ao = 3'd2;
               6'h0a: ao = 3'd7;
               6'h0c: begin ao = 3'd0; ez = 1; end
               6'h0d: begin ao = 3'd1; ez = 1; end
               6'h0e: begin ao = 3'd3; ez = 1; end
               default: ao = 3'd2;
            endcase
         end
         5'd11: rw = 1;
         5'd12: begin rw = 1; m2r = 2'b10; end
         5'd14: begin pw = 1; ps = 2'b10; rw = 1; rd = 2'b10;
                      m2r = 2'b11; end
         5'd15: begin pw = 1; ps = 2'b11; end
         default: ;
      endcase
      return {mr, mw, cm, io, ir, rw, pw, pwc, sa, ez, br,
              rd, m2r, sb, ps, ao};
   endfunction

   // Drive one cycle and queue the expectation for it.
   task automatic cyc(string tag, logic rdy, logic ovf, logic zr,
                      logic [31:0] ins, logic [4:0] st);
      mio_ready = rdy;
      overflow  = ovf;
      zero      = zr;
      inst_in   = ins;
      q_tag.push_back(tag);
      q_st.push_back(st);
      q_vec.push_back(mdl(st, rdy, ins));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(string tag);
      reset = 1'b1;
      #1;
      chk({tag, " st"}, 32'(state_out), 32'd0);
      chk({tag, " mw"}, 32'(mem_write), 32'd0);
      chk({tag, " rw"}, 32'(reg_write), 32'd0);
      #1;
      reset = 1'b0;
   endtask

   // Scoreboard compare on the falling edge.
   always @(negedge clk) begin
      if (q_st.size() != 0) begin
         string t;
         logic [4:0] s;
         logic [21:0] v;
         t = q_tag.pop_front();
         s = q_st.pop_front();
         v = q_vec.pop_front();
         chk({t, " st"}, 32'(state_out), 32'(s));
         chk({t, " out"}, 32'(obs), 32'(v));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   localparam logic [31:0] I_LW   = 32'h8C220004;
   localparam logic [31:0] I_SW   = 32'hAC220004;
   localparam logic [31:0] I_ADD  = 32'h00221820;
   localparam logic [31:0] I_SUB  = 32'h00221822;
   localparam logic [31:0] I_BNE  = 32'h14220003;
   localparam logic [31:0] I_BEQ  = 32'h10220003;
   localparam logic [31:0] I_JAL  = 32'h0C000010;
   localparam logic [31:0] I_JR   = 32'h03E00008;
   localparam logic [31:0] I_ORI  = 32'h34220FF0;
   localparam logic [31:0] I_ADDI = 32'h20220005;
   localparam logic [31:0] I_LUI  = 32'h3C011234;
   localparam logic [31:0] I_BAD  = 32'hFC000000;

   initial begin
      reset = 1'b1;
      inst_in = '0; zero = 0; overflow = 0; mio_ready = 0;
      @(posedge clk);
      #1;
      cyc("rst", 0, 0, 0, I_LW, 5'd0);
      reset = 1'b0;

      cyc("lw if0", 0, 0, 0, I_LW, 5'd0);
      cyc("lw if1", 0, 0, 0, I_LW, 5'd0);
      cyc("lw if2", 0, 0, 0, I_LW, 5'd0);
      cyc("lw ifr", 1, 0, 0, I_LW, 5'd0);
      cyc("lw id",  0, 0, 0, I_LW, 5'd1);
      cyc("lw ex",  0, 0, 0, I_LW, 5'd2);
      cyc("lw rd0", 0, 0, 0, I_LW, 5'd3);
      cyc("lw rd1", 0, 0, 0, I_LW, 5'd3);
      cyc("lw rdr", 1, 0, 0, I_LW, 5'd3);
      cyc("lw wb",  0, 0, 0, I_LW, 5'd4);

      cyc("sub if", 1, 0, 0, I_SUB, 5'd0);
      cyc("sub id", 0, 0, 0, I_SUB, 5'd1);
      cyc("sub ex", 0, 0, 0, I_SUB, 5'd6);
      cyc("sub wb", 0, 0, 0, I_SUB, 5'd7);

      cyc("bne if", 1, 0, 0, I_BNE, 5'd0);
      cyc("bne id", 0, 0, 0, I_BNE, 5'd1);
      cyc("bne ex", 0, 0, 0, I_BNE, 5'd13);
      cyc("beq if", 1, 0, 1, I_BEQ, 5'd0);
      cyc("beq id", 0, 0, 1, I_BEQ, 5'd1);
      cyc("beq ex", 0, 0, 1, I_BEQ, 5'd8);

      cyc("jal if", 1, 0, 0, I_JAL, 5'd0);
      cyc("jal id", 0, 0, 0, I_JAL, 5'd1);
      cyc("jal ex", 0, 0, 0, I_JAL, 5'd14);
      cyc("jr if",  1, 0, 0, I_JR, 5'd0);
      cyc("jr id",  0, 0, 0, I_JR, 5'd1);
      cyc("jr ex",  0, 0, 0, I_JR, 5'd15);

      cyc("ori if", 1, 0, 0, I_ORI, 5'd0);
      cyc("ori id", 0, 0, 0, I_ORI, 5'd1);
      cyc("ori ex", 0, 1, 0, I_ORI, 5'd10);
      cyc("ori wb", 0, 0, 0, I_ORI, 5'd11);
      cyc("lui if", 1, 0, 0, I_LUI, 5'd0);
      cyc("lui id", 0, 0, 0, I_LUI, 5'd1);
      cyc("lui wb", 0, 0, 0, I_LUI, 5'd12);

      cyc("ovf if", 1, 0, 0, I_ADD, 5'd0);
      cyc("ovf id", 0, 0, 0, I_ADD, 5'd1);
      cyc("ovf ex", 0, 1, 0, I_ADD, 5'd6);
      cyc("ovf e0", 1, 0, 0, I_ADD, 5'd31);
      cyc("ovf e1", 1, 0, 0, I_ADD, 5'd31);
      do_reset("ovf rst");

      cyc("addi if", 1, 0, 0, I_ADDI, 5'd0);
      cyc("addi id", 0, 0, 0, I_ADDI, 5'd1);
      cyc("addi ex", 0, 1, 0, I_ADDI, 5'd10);
      cyc("addi er", 1, 0, 0, I_ADDI, 5'd31);
      do_reset("addi rst");

      cyc("bad if", 1, 0, 0, I_BAD, 5'd0);
      cyc("bad id", 0, 0, 0, I_BAD, 5'd1);
      cyc("bad er", 1, 0, 0, I_BAD, 5'd31);
      do_reset("bad rst");

      cyc("sw if", 1, 0, 0, I_SW, 5'd0);
      cyc("sw id", 0, 0, 0, I_SW, 5'd1);
      cyc("sw ex", 0, 0, 0, I_SW, 5'd2);
      cyc("sw w0", 0, 0, 0, I_SW, 5'd5);
      do_reset("sw rst");
      cyc("sw aft", 0, 0, 0, I_SW, 5'd0);

      chk("sb drain", 32'(q_st.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
